// File: rtl/store_checker_pkg.sv
// store_checker_pkg
//   Shared types for the end-of-test store checker: FSM state encoding,
//   failure codes and the expected-store table entry.
//   Table entries are stored at a fixed maximum width and zero-extended on
//   write, so the package stays parameter-free; ADDR_W and DATA_W of the
//   checker must not exceed MAX_ADDR_W and MAX_DATA_W.
package store_checker_pkg;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fail_code_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/store_checker_table.sv
// store_checker_table
//   NUM_EXP-entry register file holding the expected (address, data) stores.
//   Ports:
//     clk, reset_n : clock, async active-low reset (clears every entry)
//     wr_en        : write strobe (caller gates it to the IDLE state)
//     wr_idx       : entry to write; indices >= NUM_EXP are dropped
//     wr_entry     : entry contents
//     rd_idx       : combinational read index (the checker's exp_ptr)
//     rd_entry     : entry at rd_idx, or all-zero when rd_idx >= NUM_EXP
module store_checker_table
    import store_checker_pkg::*;
#(
    parameter int NUM_EXP = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  exp_entry_t       wr_entry,
    input  logic [IDX_W:0]   rd_idx,
    output exp_entry_t       rd_entry
);

    exp_entry_t mem [NUM_EXP];

    // Decoding each entry against its own index drops out-of-range writes
    // without a range compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    mem[i] <= wr_entry;
                end
            end
        end
    end

    always_comb begin
        rd_entry = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (rd_idx == (IDX_W + 1)'(i)) begin
                rd_entry = mem[i];
            end
        end
    end

endmodule

// File: rtl/store_checker.sv
// store_checker
//   End-of-test monitor for the memory-stage write port. Compares the
//   program's stores, in order, against a loadable table of expected
//   (address, data) pairs, filters an optional scratch address, enforces a
//   cycle timeout and reports a sticky verdict with capture registers.
//   Ports:
//     clk, reset_n           : clock, async active-low reset
//     mem_write_m,
//     data_address_m,
//     store_data_m           : observed store port
//     exp_wr_en/idx/addr/data: table load port (IDLE only)
//     exp_count, scratch_en  : run configuration, sampled on start
//     start, clear           : begin a run / leave a verdict state
//     done, pass, fail,
//     fail_code, fail_addr,
//     fail_data              : registered verdict
//     exp_ptr, cycle_count,
//     store_count            : registered progress counters
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | table loadable, waiting for start
//   RUN   | checking stores, counting cycles toward the timeout
//   PASS  | all expected stores seen in order (sticky until clear)
//   FAIL  | mismatch or timeout (sticky until clear)
module store_checker
    import store_checker_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                NUM_EXP      = 4,
    parameter int                IDX_W        = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    parameter logic [ADDR_W-1:0] SCRATCH_ADDR = 96,
    parameter int                TIMEOUT      = 1000,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_write_m,
    input  logic [ADDR_W-1:0] data_address_m,
    input  logic [DATA_W-1:0] store_data_m,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_wr_idx,
    input  logic [ADDR_W-1:0] exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [IDX_W:0]    exp_count,
    input  logic              scratch_en,
    input  logic              start,
    input  logic              clear,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    exp_ptr,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count
);

    localparam logic [IDX_W:0]   NUM_EXP_C = (IDX_W + 1)'(NUM_EXP);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              scratch_q, scratch_d;
    logic [IDX_W:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  stc_q, stc_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    fail_code_t        fc_q, fc_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;

    exp_entry_t        wr_entry;
    exp_entry_t        cur_entry;

    logic [IDX_W:0]    count_clamped;
    logic [IDX_W:0]    ptr_inc;
    logic [CNT_W-1:0]  cyc_inc;
    logic [CNT_W-1:0]  stc_inc;
    logic              relevant;
    logic              hit;
    logic              last;
    logic              timeout;

    assign wr_entry.addr = MAX_ADDR_W'(exp_wr_addr);
    assign wr_entry.data = MAX_DATA_W'(exp_wr_data);

    store_checker_table #(
        .NUM_EXP (NUM_EXP),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (exp_wr_en && (state_q == IDLE)),
        .wr_idx   (exp_wr_idx),
        .wr_entry (wr_entry),
        .rd_idx   (ptr_q),
        .rd_entry (cur_entry)
    );

    assign count_clamped = (exp_count > NUM_EXP_C) ? NUM_EXP_C : exp_count;
    assign ptr_inc       = ptr_q + (IDX_W + 1)'(1);
    assign cyc_inc       = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    assign stc_inc       = (stc_q == '1) ? stc_q : stc_q + CNT_W'(1);

    // Scratch filtering takes priority over table comparison.
    assign relevant = mem_write_m && !(scratch_q && (data_address_m == SCRATCH_ADDR));
    assign hit      = (cur_entry.addr == MAX_ADDR_W'(data_address_m)) &&
                      (cur_entry.data == MAX_DATA_W'(store_data_m));
    assign last     = (ptr_inc == count_q);
    assign timeout  = (cyc_q == TIMEOUT_C);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        scratch_d = scratch_q;
        ptr_d     = ptr_q;
        cyc_d     = cyc_q;
        stc_d     = stc_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        fc_d      = fc_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d   = count_clamped;
                    scratch_d = scratch_en;
                    ptr_d     = '0;
                    cyc_d     = '0;
                    stc_d     = '0;
                    if (count_clamped == '0) begin
                        state_d = PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                // A deciding store (final match or mismatch) beats the
                // timeout; a non-final match in the timeout cycle does not.
                if (relevant && hit && last) begin
                    state_d = PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    ptr_d   = ptr_inc;
                    stc_d   = stc_inc;
                    cyc_d   = cyc_inc;
                end else if (relevant && !hit) begin
                    state_d = FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    fc_d    = FC_MISMATCH;
                    faddr_d = data_address_m;
                    fdata_d = store_data_m;
                    stc_d   = stc_inc;
                    cyc_d   = cyc_inc;
                end else if (timeout) begin
                    state_d = FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    cyc_d = cyc_inc;
                    if (relevant) begin
                        ptr_d = ptr_inc;
                        stc_d = stc_inc;
                    end
                end
            end

            PASS, FAIL: begin
                if (clear) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    fc_d    = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            scratch_q <= 1'b0;
            ptr_q     <= '0;
            cyc_q     <= '0;
            stc_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            fc_q      <= FC_NONE;
            faddr_q   <= '0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            scratch_q <= scratch_d;
            ptr_q     <= ptr_d;
            cyc_q     <= cyc_d;
            stc_q     <= stc_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            fc_q      <= fc_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fc_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign exp_ptr     = ptr_q;
    assign cycle_count = cyc_q;
    assign store_count = stc_q;

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker
//   Randomized plus directed bench for store_checker. The driver pushes the
//   expected verdict of each run into a scoreboard queue; a monitor pops and
//   compares whenever done rises.
module tb_store_checker;

    localparam int NUM_EXP = 3;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 20;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int CW      = 16;
    localparam logic [31:0] SCR = 32'd96;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              mem_write_m = 1'b0;
    logic [AW-1:0]     data_address_m = '0;
    logic [DW-1:0]     store_data_m = '0;
    logic              exp_wr_en = 1'b0;
    logic [IDX_W-1:0]  exp_wr_idx = '0;
    logic [AW-1:0]     exp_wr_addr = '0;
    logic [DW-1:0]     exp_wr_data = '0;
    logic [IDX_W:0]    exp_count = '0;
    logic              scratch_en = 1'b0;
    logic              start = 1'b0;
    logic              clear = 1'b0;
    logic              done, pass, fail;
    logic [1:0]        fail_code;
    logic [AW-1:0]     fail_addr;
    logic [DW-1:0]     fail_data;
    logic [IDX_W:0]    exp_ptr;
    logic [CW-1:0]     cycle_count, store_count;

    store_checker #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .NUM_EXP      (NUM_EXP),
        .IDX_W        (IDX_W),
        .SCRATCH_ADDR (SCR),
        .TIMEOUT      (TIMEOUT),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_write_m    (mem_write_m),
        .data_address_m (data_address_m),
        .store_data_m   (store_data_m),
        .exp_wr_en      (exp_wr_en),
        .exp_wr_idx     (exp_wr_idx),
        .exp_wr_addr    (exp_wr_addr),
        .exp_wr_data    (exp_wr_data),
        .exp_count      (exp_count),
        .scratch_en     (scratch_en),
        .start          (start),
        .clear          (clear),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .fail_code      (fail_code),
        .fail_addr      (fail_addr),
        .fail_data      (fail_data),
        .exp_ptr        (exp_ptr),
        .cycle_count    (cycle_count),
        .store_count    (store_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } stim_t;

    typedef struct {
        bit          ps;
        bit          fl;
        logic [1:0]  code;
        logic [31:0] fa;
        logic [31:0] fd;
        logic [2:0]  ptr;
        logic [15:0] sc;
        logic [15:0] cc;
    } exp_t;

    exp_t        sb_q[$];
    stim_t       stims[$];
    logic [31:0] m_a [NUM_EXP];
    logic [31:0] m_d [NUM_EXP];
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input bit ps, input logic [1:0] code, input logic [31:0] fa,
                                input logic [31:0] fd, input int ptr, input int sc, input int cc);
        exp_t e;
        e.ps = ps; e.fl = !ps; e.code = code; e.fa = fa; e.fd = fd;
        e.ptr = 3'(ptr); e.sc = 16'(sc); e.cc = 16'(cc);
        return e;
    endfunction

    // Reference: the i-th non-ignored store in RUN must equal table entry i.
    // The run ends at the store that completes the table, at the first store
    // that differs, or at RUN cycle TIMEOUT-1 if neither happens by then.
    function automatic exp_t model(input int count, input bit scr);
        int n;
        int matched;
        n = (count > NUM_EXP) ? NUM_EXP : count;
        if (n == 0) return mk(1, 0, 0, 0, 0, 0, 0);
        matched = 0;
        for (int k = 0; k < TIMEOUT && k < stims.size(); k++) begin
            if (stims[k].wr && !(scr && stims[k].a == SCR)) begin
                if (stims[k].a == m_a[matched] && stims[k].d == m_d[matched]) begin
                    if (matched + 1 == n) return mk(1, 0, 0, 0, n, n, k + 1);
                    if (k == TIMEOUT - 1) break;
                    matched++;
                end else begin
                    return mk(0, 1, stims[k].a, stims[k].d, matched, matched + 1, k + 1);
                end
            end
        end
        return mk(0, 2, 0, 0, matched, matched, TIMEOUT - 1);
    endfunction

    // Monitor: compare on every rising edge of done.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected no verdict");
                end else begin
                    e = sb_q.pop_front();
                    chk("pass", pass, e.ps);
                    chk("fail", fail, e.fl);
                    chk("fail_code", fail_code, e.code);
                    chk("fail_addr", fail_addr, e.fa);
                    chk("fail_data", fail_data, e.fd);
                    chk("exp_ptr", exp_ptr, e.ptr);
                    chk("store_count", store_count, e.sc);
                    chk("cycle_count", cycle_count, e.cc);
                end
            end
            prev = done;
        end
    end

    task automatic write_entry(input int idx, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        exp_wr_en = 1'b1; exp_wr_idx = IDX_W'(idx); exp_wr_addr = a; exp_wr_data = d;
        @(negedge clk);
        exp_wr_en = 1'b0;
        if (idx < NUM_EXP) begin
            m_a[idx] = a;
            m_d[idx] = d;
        end
    endtask

    task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d);
        stim_t s;
        s.wr = wr; s.a = a; s.d = d;
        stims.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0);
    endtask

    // Start a run, play the stimulus list, wait for the verdict, poke the
    // table (must be ignored) and clear.
    task automatic run(input int count, input bit scr, input exp_t e, input bit start_store);
        int n;
        @(negedge clk);
        exp_count = 3'(count); scratch_en = scr; start = 1'b1;
        mem_write_m = start_store; data_address_m = 32'd104; store_data_m = 32'd84;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        scratch_en = 1'(~scr);
        foreach (stims[i]) begin
            mem_write_m = stims[i].wr; data_address_m = stims[i].a; store_data_m = stims[i].d;
            @(negedge clk);
        end
        mem_write_m = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL verdict_timeout: got done=0 after %0d cycles, expected done=1", n);
            sb_q.delete();
        end
        @(negedge clk);
        exp_wr_en = 1'b1; exp_wr_idx = 2'd0; exp_wr_addr = $urandom; exp_wr_data = $urandom;
        mem_write_m = 1'b1; data_address_m = $urandom; store_data_m = $urandom;
        @(negedge clk);
        exp_wr_en = 1'b0; mem_write_m = 1'b0;
        chk("sticky_done", done, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_done", done, 0);
        chk("clear_code", fail_code, 0);
        stims.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_EXP; i++) begin m_a[i] = 0; m_d[i] = 0; end
        #12;
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cycle", cycle_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single entry, scratch filtered, start-cycle store ignored.
        write_entry(0, 100, 84);
        add(1, 96, 7); add(1, 100, 84);
        run(1, 1, mk(1, 0, 0, 0, 1, 1, 2), 1);
        add(1, 104, 84);
        run(1, 1, mk(0, 1, 104, 84, 0, 1, 1), 0);
        add(1, 96, 7);
        run(1, 0, mk(0, 1, 96, 7, 0, 1, 1), 0);

        // Three in order with gaps, then 2 and 3 swapped.
        write_entry(1, 104, 5);
        write_entry(2, 108, 9);
        idle(1); add(1, 100, 84); idle(2); add(1, 104, 5); idle(2); add(1, 108, 9);
        run(3, 1, mk(1, 0, 0, 0, 3, 3, 8), 0);
        idle(1); add(1, 100, 84); idle(2); add(1, 108, 9); idle(2); add(1, 104, 5);
        run(3, 1, mk(0, 1, 108, 9, 1, 2, 5), 0);

        // Timeout, then a matching final store in the timeout cycle.
        run(1, 1, mk(0, 2, 0, 0, 0, 0, 19), 0);
        idle(19); add(1, 100, 84);
        run(1, 1, mk(1, 0, 0, 0, 1, 1, 20), 0);

        // After PASS and clear, count=0 passes immediately.
        run(0, 0, mk(1, 0, 0, 0, 0, 0, 0), 0);

        // Out-of-range index dropped; count clamped to NUM_EXP.
        write_entry(3, 100, 84);
        add(1, 100, 84); add(1, 104, 5); add(1, 108, 9);
        run(7, 0, mk(1, 0, 0, 0, 3, 3, 3), 0);

        // Reset in the middle of RUN.
        @(negedge clk);
        exp_count = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_cycle", cycle_count, 0);
        chk("arst_done", done, 0);
        chk("arst_ptr", exp_ptr, 0);
        for (int i = 0; i < NUM_EXP; i++) begin m_a[i] = 0; m_d[i] = 0; end
        @(negedge clk);
        reset_n = 1'b1;
        add(1, 0, 0); add(1, 0, 0);
        run(2, 0, mk(1, 0, 0, 0, 2, 2, 2), 0);
        add(1, 100, 84);
        run(1, 0, mk(0, 1, 100, 84, 0, 1, 1), 0);

        // Randomized runs against the reference model.
        for (int t = 0; t < 40; t++) begin
            int cnt;
            bit scr;
            int maxgap;
            repeat ($urandom_range(1, 4))
                write_entry($urandom_range(0, 3), 96 + 4 * $urandom_range(0, 4), $urandom_range(0, 3));
            cnt = $urandom_range(0, 7);
            scr = 1'($urandom_range(0, 1));
            maxgap = ($urandom_range(0, 3) == 0) ? 9 : 3;
            for (int j = 0; j < NUM_EXP; j++) begin
                repeat ($urandom_range(0, maxgap)) begin
                    if ($urandom_range(0, 4) == 0) add(1, SCR, $urandom_range(0, 3));
                    else add(0, 0, 0);
                end
                if ($urandom_range(0, 7) == 0) add(1, m_a[j], m_d[j] ^ 32'd1);
                else add(1, m_a[j], m_d[j]);
            end
            run(cnt, scr, model(cnt, scr), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
